// File: rtl/ysyx_23060332_dmem_pkg.sv
// ysyx_23060332_dmem_pkg: shared FSM encodings, mask width and word constants
// for the NPC data-memory responder and its lane helper.
`default_nettype none

package ysyx_23060332_dmem_pkg;

   localparam int          DMEM_MASK_W  = 4;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic        READ_ENABLE  = 1'b1;
   localparam logic        WRITE_ENABLE = 1'b1;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_BUSY = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

   // Widened so lanes pushed past lane 3 stay visible for the spill test.
   function automatic logic [2*DMEM_MASK_W-1:0] shift_mask(
      input logic [DMEM_MASK_W-1:0] mask,
      input logic [1:0]             off
   );
      return {{DMEM_MASK_W{1'b0}}, mask} << off;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060332_dmem_lane.sv
// ysyx_23060332_dmem_lane: maps byte offset, mask and right-aligned write data
// onto word byte enables / lane data, and flags misaligned accesses.
`default_nettype none

module ysyx_23060332_dmem_lane
   import ysyx_23060332_dmem_pkg::*;
(
   input  logic [1:0]             off,
   input  logic [DMEM_MASK_W-1:0] mask,
   input  logic [31:0]            wdata,
   output logic [DMEM_MASK_W-1:0] byte_en,
   output logic [31:0]            wdata_sh,
   output logic                   misalign
);

   logic [2*DMEM_MASK_W-1:0] mask_sh;

   assign mask_sh  = shift_mask(mask, off);
   assign byte_en  = mask_sh[DMEM_MASK_W-1:0];
   assign wdata_sh = wdata << {off, 3'b000};

   assign misalign = ((mask == 4'hF) && (off != 2'd0))
                   || ((mask == 4'h3) && off[0])
                   || (|mask_sh[2*DMEM_MASK_W-1:DMEM_MASK_W]);

endmodule

`default_nettype wire

// File: rtl/ysyx_23060332_dmem.sv
// ysyx_23060332_dmem: fixed-latency valid/ready data-memory responder for the NPC core.
// Define YSYX_23060332_DMEM_MISALIGN_CHK_EN to fault misaligned accesses.
`default_nettype none

module ysyx_23060332_dmem
   import ysyx_23060332_dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_ren,
   input  logic [31:0] mem_raddr,
   input  logic        mem_wen,
   input  logic [31:0] mem_waddr,
   input  logic [31:0] mem_wdata,
   input  logic [7:0]  mem_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] mem_rdata,
   output logic        resp_err
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   dmem_state_e            state;
   logic [3:0]             cnt;
   logic                   ren_q;
   logic                   wen_q;
   logic [31:0]            addr_q;
   logic [31:0]            wdata_q;
   logic [DMEM_MASK_W-1:0] mask_q;
   logic [31:0]            rdata_q;
   logic                   err_q;

   logic [31:0] mem [DEPTH];

   logic                   in_idle;
   logic                   commit;
   logic [31:0]            sel_addr;
   logic                   a_ren;
   logic                   a_wen;
   logic [31:0]            a_addr;
   logic [31:0]            a_wdata;
   logic [DMEM_MASK_W-1:0] a_mask;
   logic [31:0]            diff;
   logic                   out_of_range;
   logic [AW-1:0]          index;
   logic [DMEM_MASK_W-1:0] byte_en;
   logic [31:0]            wdata_sh;
   logic                   misalign;
   logic                   fault;
   logic                   do_write;
   logic                   do_read;
   logic [31:0]            rd_word;
   logic                   unused_bits;

   assign in_idle  = (state == DMEM_IDLE);
   assign sel_addr = mem_wen ? mem_waddr : mem_raddr;

   // With a single-cycle latency the commit happens on the accept edge itself,
   // so the access is taken straight from the request inputs.
   assign commit  = ((state == DMEM_BUSY) && (cnt == 4'd0))
                  || (in_idle && req_valid && (LATENCY == 1));
   assign a_ren   = in_idle ? mem_ren             : ren_q;
   assign a_wen   = in_idle ? mem_wen             : wen_q;
   assign a_addr  = in_idle ? sel_addr            : addr_q;
   assign a_wdata = in_idle ? mem_wdata           : wdata_q;
   assign a_mask  = in_idle ? mem_wmask[3:0]      : mask_q;

   assign diff         = a_addr - BASE_ADDR;
   assign out_of_range = (a_addr < BASE_ADDR) || (|diff[31:AW+2]);
   assign index        = diff[AW+1:2];

   ysyx_23060332_dmem_lane u_lane (
      .off      (a_addr[1:0]),
      .mask     (a_mask),
      .wdata    (a_wdata),
      .byte_en  (byte_en),
      .wdata_sh (wdata_sh),
      .misalign (misalign)
   );

`ifdef YSYX_23060332_DMEM_MISALIGN_CHK_EN
   assign fault = out_of_range || misalign;
`else
   assign fault = out_of_range;
`endif

   assign do_write = commit && !rst && (a_wen == WRITE_ENABLE) && !fault;
   assign do_read  = commit && (a_ren == READ_ENABLE) && !a_wen && !fault;
   assign rd_word  = mem[index] >> {a_addr[1:0], 3'b000};

   assign unused_bits = &{1'b0, mem_wmask[7:4], diff[1:0], misalign};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= DMEM_IDLE;
         cnt     <= 4'd0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= ZERO_WORD;
         wdata_q <= ZERO_WORD;
         mask_q  <= '0;
         rdata_q <= ZERO_WORD;
         err_q   <= 1'b0;
      end else begin
         case (state)
            DMEM_IDLE: begin
               if (req_valid) begin
                  ren_q   <= mem_ren;
                  wen_q   <= mem_wen;
                  addr_q  <= sel_addr;
                  wdata_q <= mem_wdata;
                  mask_q  <= mem_wmask[3:0];
                  cnt     <= LAT_LOAD;
                  state   <= (LATENCY == 1) ? DMEM_RESP : DMEM_BUSY;
               end
            end
            DMEM_BUSY: begin
               if (cnt == 4'd0) state <= DMEM_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            DMEM_RESP: begin
               if (resp_ready) state <= DMEM_IDLE;
            end
            default: state <= DMEM_IDLE;
         endcase

         if (commit) begin
            rdata_q <= do_read ? rd_word : ZERO_WORD;
            err_q   <= (a_ren || a_wen) && fault;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < DMEM_MASK_W; i++) begin
            if (byte_en[i]) mem[index][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   assign req_ready  = in_idle;
   assign resp_valid = (state == DMEM_RESP);
   assign mem_rdata  = rdata_q;
   assign resp_err   = err_q;

endmodule

`default_nettype wire
